// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph table, dark constants
// and the digit-index type used across the display scanner.
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Element n is the glyph for hex value n (segments a..g, active-low).
    localparam logic [15:0][6:0] GLYPH = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b1110010,  // c
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/display_scan_4dig_if.sv
// Data/control bundle between a host and the 4-digit display scanner.
interface display_scan_4dig_if;

    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output data_in, dp_in, load, enable, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  data_in, dp_in, load, enable, blank_lz,
        output seg, dp, an, frame_done
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/display_scan_4dig.sv
// Time-multiplexed 4-digit seven-segment driver with per-slot dead time,
// frame-synchronous double buffering and optional leading-zero blanking.
module display_scan_4dig
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SLOT_HZ      = 4000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_4dig_if.slave  bus
);

    localparam int SLOT = CLK_HZ / SLOT_HZ;
    localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;

    if (SLOT <= BLANK_CYCLES + 1) begin : g_bad_slot
        $error("display_scan_4dig: SLOT must exceed BLANK_CYCLES+1");
    end

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    logic [15:0]   shadow_data, active_data;
    logic [3:0]    shadow_dp, active_dp;
    logic          pending;

    logic          slot_end, frame_end, in_blank, lz_dark;
    logic [3:0]    nib;
    logic [6:0]    glyph;

    logic [6:0]    seg_p1;
    logic [3:0]    an_p1;
    logic          dp_p1;
    logic          frame_done_p1;

    assign slot_end  = (presc == PW'(SLOT - 1));
    assign frame_end = slot_end && (idx == 2'd3);
    assign in_blank  = (presc < PW'(BLANK_CYCLES));
    assign nib       = active_data[{idx, 2'b00} +: 4];

    // A digit goes dark only when it and every digit to its left are zero
    // and it carries no decimal point; digit 0 always shows.
    always_comb begin
        lz_dark = 1'b0;
        case (idx)
            2'd3:    lz_dark = ~|active_data[15:12] & ~active_dp[3];
            2'd2:    lz_dark = ~|active_data[15:8]  & ~active_dp[2];
            2'd1:    lz_dark = ~|active_data[15:4]  & ~active_dp[1];
            default: lz_dark = 1'b0;
        endcase
        lz_dark = lz_dark & bus.blank_lz;
    end

    hex_to_seg7 u_glyph (
        .nib (nib),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc         <= '0;
            idx           <= '0;
            shadow_data   <= '0;
            shadow_dp     <= '0;
            active_data   <= '0;
            active_dp     <= '0;
            pending       <= 1'b0;
            seg_p1        <= SEG_OFF;
            an_p1         <= AN_OFF;
            dp_p1         <= 1'b1;
            frame_done_p1 <= 1'b0;
        end else begin
            if (bus.enable) begin
                presc <= slot_end ? '0 : presc + 1'b1;
                if (slot_end)
                    idx <= idx + 2'd1;
                // Transfer reads the shadow before any same-cycle load lands.
                if (frame_end && pending) begin
                    active_data <= shadow_data;
                    active_dp   <= shadow_dp;
                end
            end

            if (bus.load) begin
                shadow_data <= bus.data_in;
                shadow_dp   <= bus.dp_in;
                pending     <= 1'b1;
            end else if (bus.enable && frame_end) begin
                pending     <= 1'b0;
            end

            // ---- output register stage ----
            frame_done_p1 <= bus.enable && frame_end;
            if (!bus.enable || in_blank || lz_dark) begin
                seg_p1 <= SEG_OFF;
                an_p1  <= AN_OFF;
                dp_p1  <= 1'b1;
            end else begin
                seg_p1 <= glyph;
                an_p1  <= ~(4'b0001 << idx);
                dp_p1  <= ~active_dp[idx];
            end
        end
    end

    assign bus.seg        = seg_p1;
    assign bus.an         = an_p1;
    assign bus.dp         = dp_p1;
    assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_display_scan_4dig.sv
// Randomized scoreboard bench for display_scan_4dig against a digit-level
// reference model of the scanning display.
module tb_display_scan_4dig;

    localparam int CLK_HZ = 1000;
    localparam int SLOT_HZ = 100;
    localparam int BLANK = 2;
    localparam int SLOT = CLK_HZ / SLOT_HZ;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_4dig_if bus ();

    display_scan_4dig #(
        .CLK_HZ       (CLK_HZ),
        .SLOT_HZ      (SLOT_HZ),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: position within the slot, which digit is lit, and
    // the displayed / waiting values as plain nibble arrays.
    int m_tick;
    int m_digit;
    int act_nib [4];
    int sh_nib [4];
    bit act_dp [4];
    bit sh_dp [4];
    bit m_pending;

    logic [12:0] exp_q [$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    task automatic model_clear();
        m_tick = 0;
        m_digit = 0;
        m_pending = 0;
        for (int k = 0; k < 4; k++) begin
            act_nib[k] = 0; sh_nib[k] = 0; act_dp[k] = 0; sh_dp[k] = 0;
        end
    endtask

    task automatic check_reset_pins();
        logic [12:0] got;
        got = {bus.an, bus.seg, bus.dp, bus.frame_done};
        compared++;
        if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset state got an=%b seg=%b dp=%b fd=%b",
                     got[12:9], got[8:2], got[1], got[0]);
        end
    endtask

    task automatic check_wait(input int g, input string what);
        compared++;
        if (g >= 100) begin
            mismatched++;
            $display("FAIL wait expired: %s", what);
        end
    endtask

    task automatic step(input bit r, input bit en, input bit bl, input bit ld,
                        input logic [15:0] din, input logic [3:0] dpin);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic dp_e, fd_e;
        bit lead, dark;
        @(negedge clk);
        rst_n = r;
        bus.enable = en;
        bus.blank_lz = bl;
        bus.load = ld;
        bus.data_in = din;
        bus.dp_in = dpin;
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1; fd_e = 1'b0;
        if (!r) begin
            model_clear();
        end else begin
            if (en) begin
                fd_e = (m_tick == SLOT - 1) && (m_digit == 3);
                lead = 1;
                for (int j = m_digit; j < 4; j++)
                    if (act_nib[j] != 0) lead = 0;
                dark = (m_tick < BLANK) || (bl && m_digit > 0 && lead && !act_dp[m_digit]);
                if (!dark) begin
                    an_e[m_digit] = 1'b0;
                    seg_e = glyph_tab[act_nib[m_digit]];
                    dp_e = !act_dp[m_digit];
                end
                if (fd_e && m_pending) begin
                    for (int k = 0; k < 4; k++) begin
                        act_nib[k] = sh_nib[k]; act_dp[k] = sh_dp[k];
                    end
                    m_pending = 0;
                end
                m_tick++;
                if (m_tick == SLOT) begin
                    m_tick = 0;
                    m_digit = (m_digit + 1) % 4;
                end
            end
            if (ld) begin
                for (int k = 0; k < 4; k++) begin
                    sh_nib[k] = int'(din[4*k +: 4]);
                    sh_dp[k] = dpin[k];
                end
                m_pending = 1;
            end
        end
        exp_q.push_back({an_e, seg_e, dp_e, fd_e});
    endtask

    task automatic idle(input int n, input bit bl);
        for (int i = 0; i < n; i++) step(1, 1, bl, 0, 16'h0, 4'h0);
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output.
    initial begin
        logic [12:0] want, got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got = {bus.an, bus.seg, bus.dp, bus.frame_done};
                compared++;
                if (got !== want) begin
                    mismatched++;
                    if (mismatched <= 20)
                        $display("FAIL pins cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                                 cyc, got[12:9], got[8:2], got[1], got[0],
                                 want[12:9], want[8:2], want[1], want[0]);
                end
            end
        end
    end

    initial begin
        bit en, bl;
        int guard;
        bus.enable = 1'b1; bus.blank_lz = 1'b0; bus.load = 1'b0;
        bus.data_in = '0; bus.dp_in = '0;
        model_clear();

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0, 4'h0);
        @(posedge clk);
        #2;
        check_reset_pins();

        // Load one cycle after reset, watch two frames.
        step(1, 1, 0, 0, 16'h0, 4'h0);
        step(1, 1, 0, 1, 16'h1234, 4'h0);
        idle(85, 0);

        step(1, 1, 0, 1, 16'hABCD, 4'h0);
        idle(90, 0);

        step(1, 1, 1, 1, 16'h0005, 4'h0);
        idle(85, 1);
        step(1, 1, 1, 1, 16'h0005, 4'b0100);
        idle(85, 1);

        // Load exactly on a frame boundary.
        guard = 0;
        while (!(m_tick == SLOT - 1 && m_digit == 3) && guard < 100) begin
            idle(1, 0); guard++;
        end
        check_wait(guard, "frame boundary");
        step(1, 1, 0, 1, 16'h1111, 4'h0);
        idle(90, 0);

        // Enable drop in the middle of slot 1.
        guard = 0;
        while (!(m_tick == 4 && m_digit == 1) && guard < 100) begin
            idle(1, 0); guard++;
        end
        check_wait(guard, "mid slot 1");
        for (int i = 0; i < 7; i++) step(1, 0, 0, (i == 3), 16'h9876, 4'h3);
        idle(60, 0);

        // Reset mid-slot, coinciding with a load.
        idle(13, 0);
        step(0, 1, 0, 1, 16'h4321, 4'hF);
        idle(50, 0);

        en = 1; bl = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            if ($urandom_range(0, 24) == 0) en = !en;
            if ($urandom_range(0, 99) == 0) bl = !bl;
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(($urandom_range(0, 399) != 0), en, bl,
                 ($urandom_range(0, 7) == 0), d, 4'($urandom));
        end

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
